multdiv_unit: RTL
=================

# multdiv_unit

Multi-cycle signed 32-bit multiply/divide unit in the execute stage. It serves the `mul` (ALU_op 00110) and `div` (ALU_op 00111) R-type instructions. It stalls the front of the pipeline while it iterates. When done, it hands a 32-bit result and an exception flag down the X/M and M/W latches; writeback places these in `rd` and `rstatus`. One iteration is computed per clock, so the unit needs no wide combinational array.

## Interface
- No parameters; operand width fixed at 32.
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; forces all state and outputs to reset values.
- `ctrl_mult`  in  1  start-multiply strobe, sampled on a clock edge while idle.
- `ctrl_div`  in  1  start-divide strobe, sampled on a clock edge while idle.
- `operand_a`  in  32  multiplicand / dividend (two's complement), captured with the strobe.
- `operand_b`  in  32  multiplier / divisor (two's complement), captured with the strobe.
- `rd_in`  in  5  destination register tag, captured with the strobe.
- `result`  out  32  low 32 bits of product, or quotient.
- `exception`  out  1  overflow / divide-by-zero flag for `rstatus`.
- `rd_out`  out  5  captured destination tag.
- `result_rdy`  out  1  single-cycle completion pulse.
- `busy`  out  1  high whenever the unit is not IDLE; drives the pipeline stall.

## Operation
- States:
  - IDLE: accepts strobes.
  - MUL: radix-2 Booth, 32 iterations.
  - DIV: restoring divide on magnitudes, 32 iterations.
  - FIX: sign correction and exception computation, 1 cycle.
  - DONE: `result_rdy` high, 1 cycle, then back to IDLE.
- Start from IDLE:
  - `ctrl_mult`=1 → MUL. `ctrl_div`=1 → DIV. Both high → MUL; the div strobe is dropped.
  - On the start edge, capture operands and `rd_in`, clear the 6-bit iteration counter, set `busy`.
- Strobes in any non-IDLE state are ignored. Operands and tag stay frozen.
- MUL datapath:
  - 65-bit register {P_hi[32:0], multiplier[31:0]} plus Booth bit q(-1).
  - Each iteration adds/subtracts the multiplicand, sign-extended to 33 bits, per {q0, q(-1)}, then arithmetic-shifts right 1.
  - After 32 iterations → FIX.
- DIV datapath:
  - On start, take |a| and |b|; record sign = a[31]^b[31].
  - Divide by zero (b==0) is detected on the start edge and skips to FIX with result 0, exception 1.
  - Otherwise, each iteration shifts remainder:quotient left 1, trial-subtracts |b|, and restores on negative.
  - Quotient truncates toward zero. Remainder is discarded.
- FIX rules:
  - MUL: `result` = product[31:0]. `exception`=1 iff product[63:31] is not all-equal (signed overflow).
  - DIV: `result` = sign ? -q : q. `exception`=1 for b==0 (result 0), and for a=0x80000000 with b=0xFFFFFFFF (result 0x80000000).
  - Otherwise `exception`=0.
- `result`, `exception` and `rd_out` are registered in FIX. They hold until the next FIX or reset, so downstream may sample them in DONE or later.
- Reset asserted mid-operation aborts the operation immediately. The unit returns to IDLE with no `result_rdy` pulse.

## Timing
- Reset values: `result`=0, `exception`=0, `rd_out`=0, `result_rdy`=0, `busy`=0, state IDLE, counter 0.
- Let E be the edge that samples a strobe.
- MUL and normal DIV:
  - Iteration edges are E+1 … E+32. FIX is on edge E+33, which loads `result`.
  - DONE is entered on edge E+33, so `result_rdy` is high for the cycle between E+33 and E+34.
  - The unit is IDLE after E+34, so a new strobe can be sampled on edge E+35 at the earliest.
- Divide by zero: FIX on E+1; `result_rdy` high between E+1 and E+2.
- `busy` rises right after E and falls right after the DONE cycle; it is high during the `result_rdy` cycle.
- `result_rdy` is never high for more than one consecutive cycle.
- Iteration counter is 6 bits and saturates into FIX at 32; it never wraps.

## Test plan
- a=7, b=-3, mult strobe at E → `result_rdy` only in the cycle after E+33; `result`=0xFFFFFFEB, `exception`=0, `rd_out`=tag.
- a=0x00010000, b=0x00010000, mult → `result`=0x00000000, `exception`=1. a=0xFFFFFFFF, b=0xFFFFFFFF → `result`=1, `exception`=0.
- a=-100, b=7, div → `result`=0xFFFFFFF2 (-14), `exception`=0. a=100, b=-7 → 0xFFFFFFF2.
- a=5, b=0, div → `result_rdy` in the cycle after E+1; `result`=0, `exception`=1. a=0x80000000, b=-1 → `result`=0x80000000, `exception`=1 at the E+33 timing.
- Both strobes high with a=6, b=4 → product 24. A `ctrl_div` pulse with new operands at E+10 is ignored: `result` is still 24 and no second `result_rdy` occurs.
- Assert `reset` low at E+15 of a multiply → all outputs 0 asynchronously and no `result_rdy`. After release, a fresh a=3, b=3 mult returns 9.

Source files
------------

// File: rtl/multdiv_unit.sv
// multdiv_unit: iterative signed 32-bit multiply (radix-2 Booth) and
// divide (restoring, on magnitudes). One iteration per clock. Results,
// exception flag and destination tag are registered in FIX and held.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic        ctrl_div,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  rd_in,
  output logic [31:0] result,
  output logic        exception,
  output logic [4:0]  rd_out,
  output logic        result_rdy,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  // hi: Booth partial product P_hi (33 bits) or divide remainder.
  // lo: multiplier/product-low or dividend/quotient.
  // opb: multiplicand or divisor magnitude.
  logic [32:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] opb_q, opb_d;
  logic        qm1_q, qm1_d;
  logic        is_div_q, is_div_d;
  logic        sign_q, sign_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic [4:0]  tag_q, tag_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic [4:0]  rd_q, rd_d;

  logic        start;
  logic [32:0] mc_ext;
  logic [32:0] booth_sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic [32:0] prod_top;

  assign start = ctrl_mult | ctrl_div;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (ctrl_mult)     state_d = S_MUL;
        else if (ctrl_div) state_d = (operand_b == '0) ? S_FIX : S_DIV;
      end
      S_MUL:  if (cnt_q == 6'd31) state_d = S_FIX;
      S_DIV:  if (cnt_q == 6'd31) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    busy       = (state_q != S_IDLE);
    result_rdy = (state_q == S_DONE);
  end

  // Iteration arithmetic shared by the datapath update
  always_comb begin
    mc_ext = {opb_q[31], opb_q};
    unique case ({lo_q[0], qm1_q})
      2'b01:   booth_sum = hi_q + mc_ext;
      2'b10:   booth_sum = hi_q - mc_ext;
      default: booth_sum = hi_q;
    endcase
    rem_sh   = {hi_q[31:0], lo_q[31]};
    diff     = rem_sh - {1'b0, opb_q};
    prod_top = {hi_q[31:0], lo_q[31]};
  end

  // Datapath next-state: capture, iterate, and finalize in FIX
  always_comb begin
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    qm1_d    = qm1_q;
    is_div_d = is_div_q;
    sign_d   = sign_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    tag_d    = tag_q;
    result_d = result_q;
    exc_d    = exc_q;
    rd_d     = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d = '0;
          tag_d = rd_in;
          hi_d  = '0;
          qm1_d = 1'b0;
          if (ctrl_mult) begin
            lo_d     = operand_b;
            opb_d    = operand_a;
            is_div_d = 1'b0;
            sign_d   = 1'b0;
            dz_d     = 1'b0;
            ovf_d    = 1'b0;
          end else begin
            // |INT_MIN| wraps to 0x80000000, which is its correct unsigned magnitude.
            lo_d     = operand_a[31] ? -operand_a : operand_a;
            opb_d    = operand_b[31] ? -operand_b : operand_b;
            is_div_d = 1'b1;
            sign_d   = operand_a[31] ^ operand_b[31];
            dz_d     = (operand_b == '0);
            ovf_d    = (operand_a == INT_MIN) && (operand_b == '1);
          end
        end
      end
      S_MUL: begin
        hi_d  = {booth_sum[32], booth_sum[32:1]};
        lo_d  = {booth_sum[0], lo_q[31:1]};
        qm1_d = lo_q[0];
        cnt_d = cnt_q + 6'd1;
      end
      S_DIV: begin
        if (!diff[32]) begin
          hi_d = {1'b0, diff[31:0]};
          lo_d = {lo_q[30:0], 1'b1};
        end else begin
          hi_d = rem_sh;
          lo_d = {lo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
      end
      S_FIX: begin
        rd_d = tag_q;
        if (is_div_q) begin
          if (dz_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else begin
            result_d = sign_q ? -lo_q : lo_q;
            exc_d    = ovf_q;
          end
        end else begin
          result_d = lo_q;
          exc_d    = !((&prod_top) || (~|prod_top));
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      qm1_q    <= 1'b0;
      is_div_q <= 1'b0;
      sign_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      tag_q    <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rd_q     <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      qm1_q    <= qm1_d;
      is_div_q <= is_div_d;
      sign_q   <= sign_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rd_q     <= rd_d;
    end
  end

  assign result    = result_q;
  assign exception = exc_q;
  assign rd_out    = rd_q;

endmodule
